// File: rtl/reg_dump_tx_pkg.sv
// Shared types and constants for the register-dump UART transmitter.
// Holds the state encoding used by both the frame sequencer and the byte serialiser.
package reg_dump_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    FIN
  } state_t;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  // Header byte plus four bytes per 32-bit register.
  function automatic int frame_bytes(input int nregs);
    return 1 + 4 * nregs;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser with a valid/ready handshake.
// The last stop-bit cycle is spent in IDLE, so a waiting byte follows with no gap.
module uart_tx_byte
  import reg_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            shreg    <= data;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          // One cycle short: the final stop-bit cycle is the IDLE cycle that follows.
          if (baud_cnt == STOP_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// Snapshots the flattened register file on request and streams it as a UART frame:
// header byte, then x[0]..x[NREGS-1], each register MSB byte first.
module reg_dump_tx
  import reg_dump_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          NREGS        = 32,
  parameter logic [7:0]  HEADER       = FRAME_HEADER
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NREGS*32-1:0] registers,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam int NBYTES = frame_bytes(NREGS);
  localparam int BW     = $clog2(NBYTES) + 1;
  localparam int OW     = $clog2(NREGS * 32);

  state_t              state;
  logic [NREGS*32-1:0] shadow;
  logic [BW-1:0]       byte_idx;
  logic [BW-1:0]       data_idx;
  logic [OW-1:0]       lane_off;
  logic                tx_valid;
  logic                tx_ready;
  logic [7:0]          tx_data;
  logic                accept;

  assign accept   = (state == IDLE) && start && tx_ready;
  assign data_idx = byte_idx - BW'(1);
  // Byte n>0 is register (n-1)/4, lane 3-(n-1)%4; picked straight out of the snapshot.
  assign lane_off = OW'((int'(data_idx) / 4) * 32 + (3 - int'(data_idx) % 4) * 8);

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = HEADER;
    case (state)
      IDLE:  tx_valid = start;
      START: begin
        tx_valid = 1'b1;
        tx_data  = shadow[lane_off +: 8];
      end
      default: ;
    endcase
  end

  // NOTE: the snapshot is pure data qualified by the FSM, so it is kept out of the reset tree.
  always_ff @(posedge clk) begin
    if (accept) shadow <= registers;
  end

  // START spans the whole byte stream here; the serialiser walks START/DATA/STOP per byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            busy     <= 1'b1;
            byte_idx <= BW'(1);
          end
        end
        START: begin
          if (tx_ready) begin
            byte_idx <= byte_idx + BW'(1);
            if (byte_idx == BW'(NBYTES - 1)) state <= FIN;
          end
        end
        FIN: begin
          // Serialiser idle again means the last stop bit is in its final cycle.
          if (tx_ready) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            byte_idx <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .valid(tx_valid),
    .data (tx_data),
    .ready(tx_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: a mid-bit UART decoder collects bytes, compared against a frame
// model built from the register values; table vectors plus multi-cycle corner sequences.
module tb_reg_dump_tx;

  localparam int CPB = 4;
  localparam int NR  = 32;
  localparam int NB  = 1 + 4 * NR;
  localparam int FRAME_CYCLES = NB * 10 * CPB;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [NR*32-1:0]   registers;
  logic               tx;
  logic               busy;
  logic               done;

  reg_dump_tx #(
    .CLKS_PER_BIT(CPB),
    .NREGS       (NR),
    .HEADER      (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .registers(registers),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int frame_err = 0;
  int done_busy_viol = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] regs_m[NR];

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[11];

  // UART receiver: detects the start bit on its first cycle, samples each bit mid-way.
  always begin : rx_dec
    logic [7:0] b;
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      if (tx !== 1'b0) frame_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) frame_err++;
      rx_q.push_back(b);
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1 && busy !== 1'b0) done_busy_viol++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame: header, then every register most significant byte first.
  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < NR; r++)
      for (int lane = 3; lane >= 0; lane--)
        exp_q.push_back(regs_m[r][lane*8 +: 8]);
  endtask

  task automatic drive_regs();
    for (int i = 0; i < NR; i++) registers[i*32 +: 32] = regs_m[i];
  endtask

  task automatic random_regs();
    for (int i = 0; i < NR; i++) regs_m[i] = $urandom;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output int busy_n, output bit ok);
    cycles = 0;
    busy_n = 0;
    ok     = 1'b0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_n++;
    end
  endtask

  task automatic compare_frame(input string name, input int base, input int ferr0, input int total);
    int bad   = 0;
    int first = -1;
    check({name, "_rx_count"}, 64'(rx_q.size() - base), 64'(total));
    for (int i = 0; i < NB; i++) begin
      if (base + i < rx_q.size() && rx_q[base + i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    check($sformatf("%s_bad_bytes(first=%0d)", name, first), 64'(bad), 64'd0);
    check({name, "_framing"}, 64'(frame_err - ferr0), 64'd0);
  endtask

  initial begin : main
    int  base, fe0, cyc, bn, waited;
    bit  ok;

    vecs[0]  = '{0,   8'hA5};
    vecs[1]  = '{1,   8'h00};
    vecs[2]  = '{4,   8'h00};
    vecs[3]  = '{5,   8'hDE};
    vecs[4]  = '{6,   8'hAD};
    vecs[5]  = '{7,   8'hBE};
    vecs[6]  = '{8,   8'hEF};
    vecs[7]  = '{9,   8'h00};
    vecs[8]  = '{12,  8'h02};
    vecs[9]  = '{125, 8'h00};
    vecs[10] = '{128, 8'h1F};

    rst_n     = 1'b0;
    start     = 1'b1;
    registers = '0;

    // Reset held with start asserted: outputs stay idle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_tx", 64'(tx), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_no_frame", 64'(rx_q.size()), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_tx", 64'(tx), 64'd1);

    // Known pattern, table-driven byte checks.
    for (int i = 0; i < NR; i++) regs_m[i] = 32'(i);
    regs_m[1] = 32'hDEADBEEF;
    drive_regs();
    build_exp();
    base = rx_q.size();
    fe0  = frame_err;
    pulse_start();
    check("latency_busy", 64'(busy), 64'd1);
    check("latency_tx_start_bit", 64'(tx), 64'd0);
    wait_done(FRAME_CYCLES + 200, cyc, bn, ok);
    check("pattern_done_seen", 64'(ok), 64'd1);
    check("pattern_busy_cycles", 64'(bn + 1), 64'(FRAME_CYCLES));
    @(negedge clk);
    check("pattern_done_one_cycle", 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    compare_frame("pattern", base, fe0, NB);
    for (int v = 0; v < 11; v++) begin
      if (base + vecs[v].idx < rx_q.size())
        check($sformatf("vec_byte%0d", vecs[v].idx), 64'(rx_q[base + vecs[v].idx]), 64'(vecs[v].exp));
      else
        check($sformatf("vec_byte%0d_missing", vecs[v].idx), 64'(rx_q.size() - base), 64'(NB));
    end

    // Snapshot coherence: x[1] changes right after the request.
    base = rx_q.size();
    fe0  = frame_err;
    pulse_start();
    registers[63:32] = 32'h0;
    wait_done(FRAME_CYCLES + 200, cyc, bn, ok);
    check("snapshot_done_seen", 64'(ok), 64'd1);
    repeat (4) @(negedge clk);
    compare_frame("snapshot", base, fe0, NB);
    if (base + 8 < rx_q.size())
      check("snapshot_x1", 64'({rx_q[base+5], rx_q[base+6], rx_q[base+7], rx_q[base+8]}), 64'hDEADBEEF);
    else
      check("snapshot_x1_missing", 64'(rx_q.size() - base), 64'(NB));

    // Random registers, with start requests at cycles ~100 and ~3000 that must be ignored.
    random_regs();
    drive_regs();
    build_exp();
    base = rx_q.size();
    fe0  = frame_err;
    pulse_start();
    repeat (97) @(negedge clk);
    pulse_start();
    repeat (2898) @(negedge clk);
    pulse_start();
    wait_done(FRAME_CYCLES, cyc, bn, ok);
    check("ignore_done_seen", 64'(ok), 64'd1);
    bn = 0;
    waited = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy === 1'b1) bn++;
      if (done === 1'b1) waited++;
    end
    check("ignore_no_second_busy", 64'(bn), 64'd0);
    check("ignore_single_done", 64'(waited), 64'd0);
    compare_frame("ignore", base, fe0, NB);

    // Asynchronous reset during the 41st byte's start bit.
    random_regs();
    drive_regs();
    base = rx_q.size();
    pulse_start();
    waited = 0;
    while (rx_q.size() < base + 40 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check("midrst_reach_byte40", 64'(rx_q.size() >= base + 40), 64'd1);
    waited = 0;
    while (tx !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("midrst_tx_low_before", 64'(tx), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_async", 64'(tx), 64'd1);
    check("midrst_busy_async", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("midrst_idle_busy", 64'(busy), 64'd0);
    random_regs();
    drive_regs();
    build_exp();
    base = rx_q.size();
    fe0  = frame_err;
    pulse_start();
    wait_done(FRAME_CYCLES + 200, cyc, bn, ok);
    check("after_rst_done_seen", 64'(ok), 64'd1);
    repeat (4) @(negedge clk);
    compare_frame("after_rst", base, fe0, NB);

    // start held through the done cycle: second frame follows with one idle cycle.
    random_regs();
    drive_regs();
    build_exp();
    base = rx_q.size();
    fe0  = frame_err;
    @(negedge clk) start = 1'b1;
    wait_done(FRAME_CYCLES + 200, cyc, bn, ok);
    check("b2b_first_done", 64'(ok), 64'd1);
    @(negedge clk) start = 1'b0;
    check("b2b_restart_busy", 64'(busy), 64'd1);
    check("b2b_restart_tx", 64'(tx), 64'd0);
    wait_done(FRAME_CYCLES + 200, cyc, bn, ok);
    check("b2b_second_done", 64'(ok), 64'd1);
    check("b2b_done_spacing", 64'(cyc + 1), 64'(FRAME_CYCLES + 1));
    repeat (4) @(negedge clk);
    compare_frame("b2b_f1", base, fe0, 2 * NB);
    compare_frame("b2b_f2", base + NB, fe0, NB);

    check("done_only_with_busy_low", 64'(done_busy_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
